// File: rtl/dmem_wait_bank.sv
// -----------------------------------------------------------------------------
// dmem_wait_bank
//
// Data-memory bank for the pipelined MIPS core's data port. It has a
// configurable depth and base address, and a configurable number of wait
// states behind a req/ready handshake. After reset a hardware sweep writes zero
// to every word. Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH*4) are flagged
// and leave the memory untouched. Every committed in-range store emits a
// one-cycle trace record for the logging monitor.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   BASE_ADDR   byte address of word 0 (DEPTH*4 aligned)
//   WAIT_CYCLES wait states between acceptance and response (0..15)
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req          request strobe, sampled only while busy = 0
//   addr         byte address (bits [1:0] ignored)
//   byteen       byte write enables, 4'b0000 = read; byteen[3] -> [31:24]
//   wdata        store data, lanes aligned to the word
//   busy         high in INIT, WAIT and RESP
//   ready        one-cycle response strobe
//   rdata        response data, valid while ready = 1
//   oor_err      with ready: the access was out of range
//   trace_valid  one-cycle pulse per committed store
//   trace_addr   aligned byte address of the committed store
//   trace_data   full merged word written
// -----------------------------------------------------------------------------
module dmem_wait_bank #(
   parameter int unsigned DEPTH       = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        oor_err,
   output logic        trace_valid,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              oor_q, oor_d;
   logic              tv_q, tv_d;
   logic [31:0]       taddr_q, taddr_d;
   logic [31:0]       tdata_q, tdata_d;

   logic [31:0]       mem_q [DEPTH];

   // Access currently being resolved. With zero wait states the commit happens
   // on the accepting edge itself, so the live inputs are used in IDLE;
   // otherwise the fields captured at acceptance are used.
   logic              use_live;
   logic [31:0]       acc_addr;
   logic [3:0]        acc_be;
   logic [31:0]       acc_wdata;
   logic [31:0]       word_off;
   logic              in_range;
   logic [IDX_W-1:0]  acc_idx;
   logic [31:0]       old_word;
   logic [31:0]       merged;
   logic              is_write;
   logic              commit;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [31:0]       mem_wdata;

   assign use_live  = (state_q == S_IDLE);
   assign acc_addr  = use_live ? (addr & 32'hFFFF_FFFC) : addr_q;
   assign acc_be    = use_live ? byteen : be_q;
   assign acc_wdata = use_live ? wdata : wdata_q;

   // The subtraction wraps for addresses below the base, so the lower bound is
   // tested explicitly.
   assign word_off  = (acc_addr - BASE_ADDR) >> 2;
   assign in_range  = (acc_addr >= BASE_ADDR) && (word_off < DEPTH);
   assign acc_idx   = word_off[IDX_W-1:0];
   assign old_word  = mem_q[acc_idx];
   assign is_write  = |acc_be;

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = acc_be[b] ? acc_wdata[8*b +: 8] : old_word[8*b +: 8];
      end
   end

   assign commit = !reset &&
                   (((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd0)));

   // NOTE: every variable is given a default before the case statement, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      oor_d   = 1'b0;
      tv_d    = 1'b0;
      rdata_d = rdata_q;
      taddr_d = taddr_q;
      tdata_d = tdata_q;

      case (state_q)
         S_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (req) begin
               addr_d  = addr & 32'hFFFF_FFFC;
               be_d    = byteen;
               wdata_d = wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase

      // The response registers load on the edge entering RESP, so the strobes
      // are high for exactly the RESP cycle.
      if (commit) begin
         ready_d = 1'b1;
         if (in_range) begin
            rdata_d = is_write ? merged : old_word;
            if (is_write) begin
               tv_d    = 1'b1;
               taddr_d = acc_addr;
               tdata_d = merged;
            end
         end else begin
            rdata_d = 32'h0;
            oor_d   = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         idx_q   <= '0;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         ready_q <= 1'b0;
         rdata_q <= 32'h0;
         oor_q   <= 1'b0;
         tv_q    <= 1'b0;
         taddr_q <= 32'h0;
         tdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         oor_q   <= oor_d;
         tv_q    <= tv_d;
         taddr_q <= taddr_d;
         tdata_q <= tdata_d;
      end
   end

   // Single write port shared by the clear sweep and committed stores.
   assign mem_we    = !reset && ((state_q == S_INIT) || (commit && in_range && is_write));
   assign mem_waddr = (state_q == S_INIT) ? idx_q : acc_idx;
   assign mem_wdata = (state_q == S_INIT) ? 32'h0 : merged;

   // NOTE: the array has no reset branch so it can map onto RAM; the INIT sweep
   // clears it instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign busy        = (state_q != S_IDLE);
   assign ready       = ready_q;
   assign rdata       = rdata_q;
   assign oor_err     = oor_q;
   assign trace_valid = tv_q;
   assign trace_addr  = taddr_q;
   assign trace_data  = tdata_q;

endmodule

// File: tb/tb_dmem_wait_bank.sv
// -----------------------------------------------------------------------------
// tb_dmem_wait_bank
//
// Several bank configurations side by side on one clock: latency variants,
// a full-size bank for the range boundary, and a bank at a non-zero base.
// Directed table vectors, multi-cycle sequences (clear, held req, reset during
// WAIT) and randomized accesses are checked against a word-array model.
// -----------------------------------------------------------------------------
module tb_dmem_wait_bank;

   localparam int NI = 6;
   localparam int          DEP_T  [NI] = '{16, 16, 16, 16, 4096, 16};
   localparam int          WT_T   [NI] = '{2, 0, 1, 5, 2, 3};
   localparam logic [31:0] BASE_T [NI] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] rst, req;
   logic [31:0]   addr  [NI];
   logic [3:0]    byteen[NI];
   logic [31:0]   wdata [NI];
   logic [NI-1:0] busy, ready, oor, tv;
   logic [31:0]   rdata [NI];
   logic [31:0]   taddr [NI];
   logic [31:0]   tdata [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_wait_bank #(
         .DEPTH      (DEP_T[g]),
         .BASE_ADDR  (BASE_T[g]),
         .WAIT_CYCLES(WT_T[g])
      ) u_dut (
         .clk        (clk),
         .reset      (rst[g]),
         .req        (req[g]),
         .addr       (addr[g]),
         .byteen     (byteen[g]),
         .wdata      (wdata[g]),
         .busy       (busy[g]),
         .ready      (ready[g]),
         .rdata      (rdata[g]),
         .oor_err    (oor[g]),
         .trace_valid(tv[g]),
         .trace_addr (taddr[g]),
         .trace_data (tdata[g])
      );
   end

   typedef struct {
      logic        seen;
      logic [31:0] rdata;
      logic        oor;
      logic        tv;
      logic [31:0] taddr;
      logic [31:0] tdata;
      int          lat;
      logic        ready_after;
   } resp_t;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        oor;
      logic        tv;
      logic [31:0] td;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference contents of the 16-word banks, indexed by word.
   logic [31:0] mdl [NI][16];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while (busy[k] && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (busy[k]) check($sformatf("idle timeout dut%0d", k), 32'(busy[k]), 32'h0);
   endtask

   // One request through the handshake; starts and ends on a falling edge.
   task automatic access(input int k, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output resp_t r);
      int n;
      wait_idle(k);
      req[k] = 1'b1; addr[k] = a; byteen[k] = be; wdata[k] = wd;
      @(posedge clk);
      @(negedge clk);
      // Fields scrambled after acceptance must have no effect.
      req[k] = 1'b0; addr[k] = $urandom; byteen[k] = 4'($urandom); wdata[k] = $urandom;
      n = 0;
      while (!ready[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
      r.seen  = ready[k];
      r.rdata = rdata[k];
      r.oor   = oor[k];
      r.tv    = tv[k];
      r.taddr = taddr[k];
      r.tdata = tdata[k];
      r.lat   = n;
      @(negedge clk);
      r.ready_after = ready[k] | tv[k];
   endtask

   task automatic chk_resp(input string nm, input resp_t g, input logic [31:0] rd,
                           input logic o, input logic t, input logic [31:0] ta,
                           input logic [31:0] td, input int lat);
      check({nm, " ready"}, 32'(g.seen), 32'h1);
      check({nm, " rdata"}, g.rdata, rd);
      check({nm, " oor"}, 32'(g.oor), 32'(o));
      check({nm, " tv"}, 32'(g.tv), 32'(t));
      if (t) begin
         check({nm, " taddr"}, g.taddr, ta);
         check({nm, " tdata"}, g.tdata, td);
      end
      check({nm, " latency"}, 32'(g.lat), 32'(lat));
      check({nm, " one-cycle"}, 32'(g.ready_after), 32'h0);
   endtask

   // Expected response from the bank's rules; updates the model on stores.
   function automatic resp_t model(input int k, input logic [31:0] a,
                                   input logic [3:0] be, input logic [31:0] wd);
      resp_t e;
      longint unsigned al, base;
      int idx;
      e.seen = 1'b1; e.rdata = 32'h0; e.oor = 1'b0; e.tv = 1'b0;
      e.taddr = 32'h0; e.tdata = 32'h0; e.lat = WT_T[k]; e.ready_after = 1'b0;
      al   = longint'(a) & 64'hFFFF_FFFC;
      base = longint'(BASE_T[k]);
      if (al >= base && (al - base) / 4 < longint'(DEP_T[k])) begin
         idx = int'((al - base) / 4);
         for (int b = 0; b < 4; b++)
            if (be[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
         e.rdata = mdl[k][idx];
         if (be != 4'h0) begin
            e.tv = 1'b1; e.taddr = 32'(al); e.tdata = mdl[k][idx];
         end
      end else begin
         e.oor = 1'b1;
      end
      return e;
   endfunction

   vec_t  tab [10];
   resp_t r, e;

   initial begin
      tab[0] = '{32'h10, 4'hF, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};
      tab[1] = '{32'h10, 4'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
      tab[2] = '{32'h12, 4'h2, 32'h0000_AB00, 32'h1234_AB78, 1'b0, 1'b1, 32'h1234_AB78};
      tab[3] = '{32'h13, 4'h0, 32'h0,         32'h1234_AB78, 1'b0, 1'b0, 32'h0};
      tab[4] = '{32'h3C, 4'h9, 32'hAABB_CCDD, 32'hAA00_00DD, 1'b0, 1'b1, 32'hAA00_00DD};
      tab[5] = '{32'h3E, 4'h0, 32'h0,         32'hAA00_00DD, 1'b0, 1'b0, 32'h0};
      tab[6] = '{32'h40, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
      tab[7] = '{32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0};
      tab[8] = '{32'h00, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
      tab[9] = '{32'h01, 4'h4, 32'h0056_0000, 32'h0056_0000, 1'b0, 1'b1, 32'h0056_0000};

      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < 16; w++) mdl[k][w] = 32'h0;
         addr[k] = 32'h0; byteen[k] = 4'h0; wdata[k] = 32'h0;
      end
      req = '0;
      rst = '1;
      repeat (2) @(negedge clk);
      rst = '0;
      for (int k = 0; k < NI; k++) wait_idle(k);

      // Directed table on the 16-word, 2-wait bank.
      for (int i = 0; i < 10; i++) begin
         access(0, tab[i].a, tab[i].be, tab[i].wd, r);
         e = model(0, tab[i].a, tab[i].be, tab[i].wd);
         chk_resp($sformatf("tab%0d", i), r, tab[i].rd, tab[i].oor, tab[i].tv,
                  tab[i].a & 32'hFFFF_FFFC, tab[i].td, 2);
      end

      // Clear sweep: one-cycle reset with stored data, then INIT length and zeros.
      begin
         int n;
         rst[0] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("rst busy", 32'(busy[0]), 32'h1);
         check("rst ready", 32'(ready[0]), 32'h0);
         check("rst oor", 32'(oor[0]), 32'h0);
         check("rst tv", 32'(tv[0]), 32'h0);
         check("rst rdata", rdata[0], 32'h0);
         check("rst taddr", taddr[0], 32'h0);
         check("rst tdata", tdata[0], 32'h0);
         rst[0] = 1'b0;
         n = 0;
         while (busy[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("init length", 32'(n), 32'd16);
         for (int w = 0; w < 16; w++) mdl[0][w] = 32'h0;
         for (int w = 0; w < 16; w++) begin
            access(0, 32'(w * 4), 4'h0, 32'h0, r);
            check($sformatf("clear w%0d", w), r.rdata, 32'h0);
         end
      end

      // Reset during WAIT of a store: no response, store lost.
      begin
         int n, spurious;
         access(0, 32'h20, 4'hF, 32'h1111_2222, r);
         wait_idle(0);
         req[0] = 1'b1; addr[0] = 32'h20; byteen[0] = 4'hF; wdata[0] = 32'hDEAD_BEEF;
         @(posedge clk);
         @(negedge clk);
         req[0] = 1'b0;
         rst[0] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rst[0] = 1'b0;
         n = 0; spurious = 0;
         while (busy[0] && n < 100) begin
            if (ready[0] || tv[0]) spurious++;
            @(negedge clk);
            n++;
         end
         check("midrst no resp", 32'(spurious), 32'h0);
         check("midrst init length", 32'(n), 32'd16);
         for (int w = 0; w < 16; w++) mdl[0][w] = 32'h0;
         access(0, 32'h20, 4'h0, 32'h0, r);
         chk_resp("midrst read", r, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2);
      end

      // Latency sweep with req held high across two accesses.
      for (int k = 0; k < 4; k++) begin
         int nr, p0, p1, w;
         logic [31:0] rd0, rd1;
         w = WT_T[k];
         access(k, 32'h8, 4'hF, 32'hC0DE_0000 + 32'(k), r);
         e = model(k, 32'h8, 4'hF, 32'hC0DE_0000 + 32'(k));
         wait_idle(k);
         nr = 0; p0 = -1; p1 = -1; rd0 = 32'h0; rd1 = 32'h0;
         req[k] = 1'b1; addr[k] = 32'h8; byteen[k] = 4'h0;
         for (int t = 0; t < 3 * w + 10; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready[k]) begin
               if (nr == 0) begin p0 = t; rd0 = rdata[k]; end
               else if (nr == 1) begin p1 = t; rd1 = rdata[k]; end
               nr++;
            end
            if (t == 2 * w + 3) req[k] = 1'b0;
         end
         check($sformatf("held w%0d count", w), 32'(nr), 32'd2);
         check($sformatf("held w%0d first", w), 32'(p0), 32'(w));
         check($sformatf("held w%0d second", w), 32'(p1), 32'(2 * w + 2));
         check($sformatf("held w%0d rd0", w), rd0, mdl[k][2]);
         check($sformatf("held w%0d rd1", w), rd1, mdl[k][2]);
      end

      // Range boundary on the full-size bank.
      access(4, 32'h0, 4'hF, 32'h1122_3344, r);
      chk_resp("big w0", r, 32'h1122_3344, 1'b0, 1'b1, 32'h0, 32'h1122_3344, 2);
      access(4, 32'h4000, 4'h0, 32'h0, r);
      chk_resp("big oor rd", r, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 2);
      access(4, 32'h4000, 4'hF, 32'hFFFF_FFFF, r);
      chk_resp("big oor wr", r, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 2);
      access(4, 32'h0, 4'h0, 32'h0, r);
      chk_resp("big w0 kept", r, 32'h1122_3344, 1'b0, 1'b0, 32'h0, 32'h0, 2);
      access(4, 32'h3FFC, 4'hF, 32'h5A5A_A5A5, r);
      chk_resp("big last wr", r, 32'h5A5A_A5A5, 1'b0, 1'b1, 32'h3FFC, 32'h5A5A_A5A5, 2);
      access(4, 32'h3FFF, 4'h0, 32'h0, r);
      chk_resp("big last rd", r, 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h0, 32'h0, 2);

      // Randomized accesses across the 16-word banks.
      for (int i = 0; i < 250; i++) begin
         int k;
         logic [31:0] a, wd;
         logic [3:0] be;
         k  = (i % 5 == 4) ? 5 : (i % 5);
         a  = BASE_T[k] - 32'd32 + 32'($urandom_range(0, 95) * 4) + 32'($urandom_range(0, 3));
         be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         wd = $urandom;
         access(k, a, be, wd, r);
         e = model(k, a, be, wd);
         chk_resp($sformatf("rnd%0d d%0d a=%h", i, k, a), r, e.rdata, e.oor, e.tv,
                  e.taddr, e.tdata, e.lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_wait_bank.md
Name: dmem_wait_bank

Overview:
- Parametrised, synthesizable data-memory bank for the pipelined MIPS core's data port.
- Generalises the bench's flat zero-latency byte-enable RAM in three ways: configurable depth and base address, configurable wait states behind a req/ready handshake, and a hardware clear sweep after reset.
- Flags out-of-range accesses.
- Emits a one-cycle write-trace record per committed store for the logging monitor.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- WAIT_CYCLES, 2, wait states between request acceptance and response; range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request strobe; sampled only when busy=0
- addr  in  32  byte address; bits [1:0] ignored (word-aligned as addr & 32'hFFFF_FFFC)
- byteen  in  4  byte write enables; 4'b0000 means read; byteen[3] selects bits [31:24]
- wdata  in  32  store data, byte lanes aligned to the word
- busy  out  1  high in INIT, WAIT and RESP states
- ready  out  1  one-cycle response strobe
- rdata  out  32  response data; valid only while ready=1
- oor_err  out  1  high with ready when the access was out of range
- trace_valid  out  1  one-cycle pulse when a store commits
- trace_addr  out  32  aligned byte address of the committed store
- trace_data  out  32  full merged word written

Behaviour:
- States: INIT, IDLE, WAIT, RESP.
- Reset:
  - State goes to INIT; sweep index goes to 0.
  - busy=1; ready=0; oor_err=0; trace_valid=0; rdata=0; trace_addr=0; trace_data=0.
  - Any in-flight request is dropped and never answered.
- INIT:
  - Writes 0 to word[idx] each cycle; idx increments by 1.
  - After the edge that clears word DEPTH-1, state goes to IDLE.
  - INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - req is ignored throughout INIT.
- IDLE (busy=0):
  - On an edge N with req=1, the bank captures aligned addr, byteen and wdata.
  - Next state is WAIT with cnt=WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES=0.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt=0, state goes to RESP.
- Commit and response:
  - The access commits on the edge entering RESP, which is edge N+WAIT_CYCLES. ready is high for exactly the one cycle that follows.
  - Index = (addr - BASE_ADDR) >> 2. The access is in range iff addr >= BASE_ADDR and index < DEPTH.
  - In-range read: rdata = word[index].
  - In-range write: only lanes with byteen set are replaced. rdata = merged word; trace_valid=1; trace_addr = aligned addr; trace_data = merged word.
  - Out of range: no memory change; rdata=0; oor_err=1; trace_valid=0.
  - Write with byteen=4'b0000 never occurs; byteen=0 is always a read.
- RESP: exactly one cycle, then IDLE. busy=1, so req is not accepted in the RESP cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles; minimum 2 cycles at WAIT_CYCLES=0.
- Requester contract: hold req and its fields until acceptance. Field changes while busy=1 have no effect.
- ready, oor_err and trace_valid are never high outside RESP.
- Reset asserted in any state, including RESP: next state is INIT and outputs take their reset values; a pending write that has not yet committed is lost.
- A read of a word that was never written after reset returns 0.

Test Plan:
- Clear check (DEPTH=16 build): preload via a write before reset, then reset for 1 cycle → busy=1 for exactly 16 cycles after reset falls; a read of every word returns 32'h0.
- Full write then read: write addr=0x10, byteen=4'hF, wdata=0x12345678, accepted at edge N → ready, trace_valid=1, trace_addr=0x10 and trace_data=0x12345678 in the cycle after edge N+2. A following read of 0x10 returns 0x12345678.
- Byte merge: after the previous step, write addr=0x12 (aligned to 0x10), byteen=4'b0010, wdata=0x0000AB00 → trace_data=0x1234AB78; a read of 0x10 returns 0x1234AB78.
- Out of range: read of addr=0x4000 with DEPTH=4096, BASE=0 → ready=1, oor_err=1, rdata=0. A write to 0x4000 → trace_valid=0, and word 0 is unchanged.
- Latency sweep: WAIT_CYCLES=0, 1, 5 → ready appears after edge N, N+1 and N+5 respectively. A req held high while busy is accepted only when busy falls, with no duplicate ready.
- Reset mid-operation: assert reset during WAIT of a write to 0x20 with wdata=0xDEADBEEF → no ready and no trace pulse; after INIT completes, a read of 0x20 returns 0.
